// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared result-bus types and sizing for the CDB arbiter
package cdb_arbiter_pkg;

    localparam int ALU_RS_SIZE     = 8;
    localparam int NUM_CDB_ENTRIES = 4;
    localparam int TAG_W           = 6;
    localparam int XLEN            = 32;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  value;
        logic [XLEN-1:0]  target_pc;
    } cdb_entry_t;

    typedef cdb_entry_t [NUM_CDB_ENTRIES-1:0] cdb_t;

    // Tag 0 means "no tag", so a zero tag marks an empty slot
    function automatic logic is_valid(cdb_entry_t e);
        return e.tag != '0;
    endfunction

endpackage

// File: rtl/cdb_compactor.sv
// cdb_compactor: packs sparse valid source entries into a dense index-ordered list
module cdb_compactor
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC = ALU_RS_SIZE,
    localparam int NW = $clog2(NUM_SRC + 1),
    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  cdb_entry_t [NUM_SRC-1:0] src_i,
    output cdb_entry_t [NUM_SRC-1:0] dense_o,
    output logic [NW-1:0]            n_valid_o
);

    logic [NW-1:0] pos;

    // Running prefix popcount gives each valid entry its dense slot
    always_comb begin
        dense_o = '0;
        pos     = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (is_valid(src_i[i])) begin
                dense_o[pos[IW-1:0]] = src_i[i];
                pos = pos + NW'(1);
            end
        end
        n_valid_o = pos;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers RS results in a ring and broadcasts them oldest-first on the CDB
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC = ALU_RS_SIZE,
    parameter int NUM_OUT = NUM_CDB_ENTRIES,
    parameter int DEPTH   = 16,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int NW = $clog2(NUM_SRC + 1),
    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  cdb_entry_t [NUM_SRC-1:0] src_vals_i,
    output cdb_entry_t [NUM_OUT-1:0] cdb_vals_o,
    output logic                     src_stall_o,
    output logic [CW-1:0]            fifo_count_o,
    output logic                     overflow_o
);

    cdb_entry_t               buf_q [DEPTH];
    logic [PW-1:0]            head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]            count_q, count_d;
    cdb_entry_t [NUM_OUT-1:0] cdb_q, cdb_d;
    logic                     ovf_q, ovf_d;
    cdb_entry_t [NUM_SRC-1:0] dense;
    logic [NW-1:0]            n_new;
    int                       n_pop, n_lane_new, n_rem, n_app, space;

    cdb_compactor #(.NUM_SRC(NUM_SRC)) u_compactor (
        .src_i     (src_vals_i),
        .dense_o   (dense),
        .n_valid_o (n_new)
    );

    // Lane selection: buffered entries first, then new ones; leftovers are appended.
    // Free space is judged against occupancy before this cycle's pops.
    always_comb begin
        n_pop      = (int'(count_q) < NUM_OUT) ? int'(count_q) : NUM_OUT;
        n_lane_new = ((NUM_OUT - n_pop) < int'(n_new)) ? NUM_OUT - n_pop : int'(n_new);
        n_rem      = int'(n_new) - n_lane_new;
        space      = DEPTH - int'(count_q);
        n_app      = (n_rem < space) ? n_rem : space;
        cdb_d      = '0;
        for (int l = 0; l < NUM_OUT; l++) begin
            if (l < n_pop)
                cdb_d[l] = buf_q[head_q + PW'(l)];
            else if (l - n_pop < n_lane_new)
                cdb_d[l] = dense[IW'(l - n_pop)];
        end
        ovf_d   = ovf_q | (n_rem > space);
        count_d = CW'(int'(count_q) - n_pop + n_app);
        head_d  = head_q + PW'(n_pop);
        tail_d  = tail_q + PW'(n_app);
    end

    // Buffer RAM: surviving new entries are written at the tail in source order
    always_ff @(posedge clk) begin
        if (rst && !flush)
            for (int j = 0; j < NUM_SRC; j++)
                if (j < n_app)
                    buf_q[tail_q + PW'(j)] <= dense[IW'(n_lane_new + j)];
    end

    // Pointers, occupancy, registered lanes and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            cdb_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= flush ? '0 : head_d;
            tail_q  <= flush ? '0 : tail_d;
            count_q <= flush ? '0 : count_d;
            cdb_q   <= flush ? '0 : cdb_d;
            ovf_q   <= flush ? 1'b0 : ovf_d;
        end
    end

    assign cdb_vals_o   = cdb_q;
    assign fifo_count_o = count_q;
    assign overflow_o   = ovf_q;
    assign src_stall_o  = (DEPTH - int'(count_q)) < NUM_SRC;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed bench with a queue model of the CDB arbiter
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int NS = 8;
    localparam int NO = 4;
    localparam int D  = 16;
    localparam int CW = $clog2(D + 1);

    typedef cdb_entry_t [NS-1:0] src_t;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                flush = 1'b0;
    src_t                src_vals = '0;
    cdb_entry_t [NO-1:0] cdb_vals;
    logic                stall;
    logic [CW-1:0]       cnt;
    logic                ovf;

    int         vectors = 0;
    int         miscompares = 0;
    cdb_entry_t mq[$];
    cdb_entry_t exp_lanes [NO];
    logic       exp_ovf = 1'b0;
    bit         chk_en = 1'b0;
    int         next_tag = 1;
    int         serial = 1;

    always #5 clk = ~clk;

    cdb_arbiter #(.NUM_SRC(NS), .NUM_OUT(NO), .DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .src_vals_i   (src_vals),
        .cdb_vals_o   (cdb_vals),
        .src_stall_o  (stall),
        .fifo_count_o (cnt),
        .overflow_o   (ovf)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic cdb_entry_t fresh();
        cdb_entry_t e;
        e.tag       = TAG_W'(next_tag);
        e.value     = 32'hA000_0000 | 32'(serial);
        e.target_pc = 32'(serial * 4);
        next_tag    = (next_tag == 63) ? 1 : next_tag + 1;
        serial++;
        return e;
    endfunction

    function automatic src_t burst(input int n);
        src_t s = '0;
        for (int i = 0; i < n; i++) s[i] = fresh();
        return s;
    endfunction

    task automatic model_clear();
        mq.delete();
        for (int l = 0; l < NO; l++) exp_lanes[l] = '0;
        exp_ovf = 1'b0;
    endtask

    // One edge of the reference behaviour: ordered candidate list, first NO broadcast,
    // remaining old entries kept, new ones kept up to the space free before pops
    task automatic model_step();
        cdb_entry_t cand[$];
        int old, ro, nr, keep;
        if (flush) begin
            model_clear();
            return;
        end
        old  = mq.size();
        cand = mq;
        for (int i = 0; i < NS; i++)
            if (src_vals[i].tag != 0) cand.push_back(src_vals[i]);
        for (int l = 0; l < NO; l++)
            if (cand.size() > 0) exp_lanes[l] = cand.pop_front();
            else exp_lanes[l] = '0;
        ro   = (old > NO) ? old - NO : 0;
        nr   = cand.size() - ro;
        keep = (nr < D - old) ? nr : D - old;
        if (nr > keep) exp_ovf = 1'b1;
        mq.delete();
        for (int k = 0; k < ro + keep; k++) mq.push_back(cand[k]);
    endtask

    task automatic tick(input logic fl, input src_t s);
        @(negedge clk);
        #1;
        flush    = fl;
        src_vals = s;
        model_step();
        @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        if (chk_en && rst) begin
            for (int l = 0; l < NO; l++)
                check($sformatf("lane%0d", l), cdb_vals[l], exp_lanes[l]);
            check("count", cnt, mq.size());
            check("stall", stall, (D - mq.size()) < NS);
            check("overflow", ovf, exp_ovf);
        end
    end

    initial begin
        src_t s;
        bit   saw_stall;
        model_clear();
        repeat (2) @(posedge clk);
        #2;
        check("rst_lanes", cdb_vals, 0);
        check("rst_count", cnt, 0);
        check("rst_stall", stall, 0);
        check("rst_ovf", ovf, 0);
        @(negedge clk);
        #1;
        rst    = 1'b1;
        chk_en = 1'b1;

        s = '0;
        s[3] = '{tag: 6'd5, value: 32'hDEAD, target_pc: 32'h0};
        tick(0, s);
        check("single_tag", cdb_vals[0].tag, 5);
        check("single_val", cdb_vals[0].value, 32'hDEAD);
        check("single_lane1", cdb_vals[1], 0);
        check("single_count", cnt, 0);

        s = '0;
        for (int i = 0; i < NS; i++) s[i] = '{tag: TAG_W'(i + 1), value: 32'(i), target_pc: 32'h0};
        tick(0, s);
        for (int l = 0; l < NO; l++) check($sformatf("burst1_tag%0d", l), cdb_vals[l].tag, l + 1);
        check("burst1_count", cnt, 4);
        tick(0, '0);
        for (int l = 0; l < NO; l++) check($sformatf("burst2_tag%0d", l), cdb_vals[l].tag, l + 5);
        check("burst2_count", cnt, 0);

        saw_stall = 0;
        for (int c = 0; c < 30; c++) begin
            if (stall) tick(0, '0);
            else tick(0, burst(NS));
            if (stall) saw_stall = 1;
        end
        check("bp_saw_stall", saw_stall, 1);
        check("bp_no_ovf", ovf, 0);
        repeat (6) tick(0, '0);
        check("bp_drained", cnt, 0);

        for (int c = 0; c < 80; c++) begin
            s = '0;
            if (!stall && $urandom_range(0, 3) != 0)
                for (int i = 0; i < NS; i++)
                    if ($urandom_range(0, 2) == 0) s[i] = fresh();
            tick(0, s);
        end
        repeat (6) tick(0, '0);
        check("wrap_no_ovf", ovf, 0);
        check("wrap_drained", cnt, 0);

        tick(0, burst(8));
        tick(0, burst(6));
        check("flush_pre_count", cnt, 6);
        tick(1, burst(2));
        for (int l = 0; l < NO; l++) check($sformatf("flush_lane%0d", l), cdb_vals[l], 0);
        check("flush_count", cnt, 0);
        repeat (3) tick(0, '0);

        repeat (3) tick(0, burst(8));
        check("ovf_pre_count", cnt, 12);
        tick(0, burst(8));
        check("ovf_set", ovf, 1);
        check("ovf_count", cnt, 12);
        repeat (4) tick(0, '0);
        check("ovf_sticky", ovf, 1);
        tick(1, '0);
        check("ovf_flush_clr", ovf, 0);

        tick(0, burst(8));
        tick(0, burst(8));
        check("prerst_lane0_live", cdb_vals[0].tag != 0, 1);
        rst = 1'b0;
        #1;
        check("midrst_lanes", cdb_vals, 0);
        check("midrst_count", cnt, 0);
        check("midrst_stall", stall, 0);
        src_vals = '0;
        model_clear();
        @(negedge clk);
        #1;
        rst = 1'b1;
        repeat (3) tick(0, '0);
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

- Receive side of the functional-unit result path.
- Collects per-slot result entries from a reservation station's CDB outputs, one per RS slot, each held for one cycle.
- Queues them in a circular buffer and broadcasts up to `NUM_CDB_ENTRIES` of them per cycle, oldest first, on the common data bus.
- The RS, ROB and register file snoop that bus.
- Throttles the sources with a stall signal so that no result is lost.

## Interface
Parameters:
- `NUM_SRC`, default `` `ALU_RS_SIZE `` (8): number of source slots.
- `NUM_OUT`, default `` `NUM_CDB_ENTRIES ``: CDB lanes per cycle.
- `DEPTH`, default 16: buffer entries. Must be a power of two and ≥ `NUM_SRC`.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `flush` in 1: synchronous pipeline flush.
- `src_vals_i` in `NUM_SRC`×`cdb_entry_t`: source results. Entry valid iff `tag != 0`.
- `cdb_vals_o` out `cdb_t` (`NUM_OUT` entries): broadcast lanes, registered. Unused lane = all-zero.
- `src_stall_o` out 1: sources must not present new results next cycle.
- `fifo_count_o` out `$clog2(DEPTH+1)`: current buffer occupancy.
- `overflow_o` out 1: sticky error, set when an entry was dropped.

## Operation
- **Valid entries:** tag 0 is reserved as "no tag". Any source entry with a nonzero tag is a result; an entry with tag 0 is ignored.
- **Candidate list:** each cycle a combined, ordered candidate list is formed:
  - buffered entries first, oldest first (head to tail);
  - then this cycle's valid source entries, in ascending source index.
- **Broadcast:** the first min(`NUM_OUT`, candidates) go to `cdb_vals_o` lanes 0.. in order. Remaining lanes are zero.
- **Buffering:** remaining candidates go into the buffer. Buffered ones stay in place (head advances by number popped). New ones are appended at tail, preserving order.
- **Pointers:**
  - `head`/`tail` are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`.
  - `count_next = count + n_in − n_out`.
- **Stall:** `src_stall_o = (DEPTH − count) < NUM_SRC`, combinational from the `count` register.
- **Overflow:** if appends exceed free space, excess source entries are dropped, highest source index first. `overflow_o` is set and held until reset or flush. Correct sources never trigger this.
- **Flush (`flush=1`):**
  - at the edge: `head`/`tail`/`count` ← 0, `cdb_vals_o` ← all-zero, `overflow_o` ← 0;
  - source entries presented that cycle are discarded.
- **Reset (`rst=0`):** the same clears as flush, applied asynchronously. Valid mid-operation; all buffered results are lost.
- **Output ordering:** no tag is broadcast twice. Results from one source keep their arrival order.

## Timing
- Latency: a source entry sampled at edge E appears on `cdb_vals_o` after edge E if it fits within lanes after older buffered entries. Otherwise it appears after a later edge.
- Throughput: `NUM_OUT` results per cycle sustained.
- Lane hold: a lane is valid for exactly one cycle per result. There is no handshake from consumers; the CDB is always accepted.
- Stall response:
  - `src_stall_o` reflects `count` after each edge;
  - sources sample it and withhold at the next edge;
  - one cycle of in-flight entries is absorbed by the `NUM_SRC` margin.
- Reset values:
  - `cdb_vals_o` all-zero;
  - `src_stall_o` 0 (unless `DEPTH < NUM_SRC`, disallowed);
  - `fifo_count_o` 0;
  - `overflow_o` 0.
- Simultaneous full buffer pop and source push of `NUM_SRC` entries is legal whenever stall was low.

## Structure
- Package `structs`: `cdb_entry_t` {tag, value, target_pc} and `cdb_t` (array of `` `NUM_CDB_ENTRIES `` entries).
- `macros.sv`: `ALU_RS_SIZE` and `NUM_CDB_ENTRIES`.
- Sub-module `cdb_compactor`: packs `NUM_SRC` sparse valid entries into a dense, index-ordered list plus a valid count, using a prefix popcount.
- The arbiter holds the buffer RAM (logic style), pointers, lane selection and flags.

## Test plan
- **Single result, idle:** source 3 presents tag 5, value `0xDEAD` for one cycle → after next edge lane 0 = {5, `0xDEAD`}, other lanes zero, count 0.
- **Burst:** all 8 sources present tags 1–8 in one cycle, `NUM_OUT`=4 → cycle 1 lanes tags 1–4, cycle 2 lanes tags 5–8, count 4 then 0.
- **Backpressure:** repeated 8-entry bursts → `src_stall_o` rises when count > 8. No `overflow_o`. Every tag is seen exactly once, in order.
- **Wrap-around:** more than 3×`DEPTH` results streamed with random gaps → pointers wrap and output order matches a scoreboard.
- **Flush and reset:** flush with count 6 while 2 sources are valid → next cycle lanes zero, count 0, discarded tags never broadcast. Asserting `rst` low mid-burst → outputs zero immediately.
- **Overflow:** force 8 entries while count = 12 → overflow set, tags from the highest sources dropped, earlier tags still delivered.
